wb_master_if: RTL
=================

// Module: wb_master_if
// PURPOSE
//  CPU-side bus master for the MIPS data (or instruction) port. Converts a
//  single-cycle pipeline memory request into a held bus transaction toward the
//  RAM/peripheral slave and waits for bus_ack_i. Stalls the pipeline while the
//  transaction is in flight and returns read data to the MEM stage.
//  Sits between the MEM stage / ctrl unit and the bus slave (ram).
// PARAMETERS
//  ADDR_W          32   bus/CPU address width
//  DATA_W          32   bus/CPU data width
//  TIMEOUT_CYCLES  255  BUSY cycles without ack before abort; 0 = never time out
// PORTS
//  clk           in   1       system clock; all state on rising edge
//  rst           in   1       synchronous, active-high reset
//  cpu_ce_i      in   1       memory request valid (sampled in IDLE only)
//  cpu_we_i      in   1       1 = write, 0 = read
//  cpu_addr_i    in   ADDR_W  request address
//  cpu_data_i    in   DATA_W  write data
//  cpu_data_o    out  DATA_W  read data to MEM stage
//  stall_i       in   1       pipeline held by another source (ctrl)
//  flush_i       in   1       pipeline flush (exception); aborts request
//  stall_req_o   out  1       stall request to ctrl (combinational)
//  bus_err_o     out  1       one-cycle pulse on timeout abort
//  bus_addr_o    out  ADDR_W  registered bus address
//  bus_data_o    out  DATA_W  registered bus write data
//  bus_data_i    in   DATA_W  bus read data (valid with ack)
//  bus_select_o  out  1       registered bus strobe/select
//  bus_we_o      out  1       registered bus write enable
//  bus_ack_i     in   1       slave acknowledge
// BEHAVIOUR
//  States: IDLE, BUSY, WAIT_STALL. Reset -> IDLE; all bus_* outputs, rd_buf,
//   timeout counter, bus_err_o = 0; cpu_data_o = 0; stall_req_o = 0.
//  IDLE: cpu_ce_i=1 & flush_i=0 -> latch addr/data/we into bus_*_o,
//   bus_select_o<=1, counter<=0, go BUSY. stall_req_o=1 combinationally in
//   this cycle. Otherwise stall_req_o=0, cpu_data_o=0.
//  BUSY: bus_addr_o/bus_data_o/bus_we_o/bus_select_o held stable.
//   - flush_i=1 (priority over ack): bus_select_o<=0, bus_we_o<=0, rd_buf<=0,
//     go IDLE; stall_req_o=0 this cycle. Same-cycle ack ignored.
//   - bus_ack_i=1: stall_req_o=0; cpu_data_o=bus_data_i if read, 0 if write
//     (combinational pass-through); bus_select_o<=0, bus_we_o<=0;
//     rd_buf<=bus_data_i (read) or 0 (write); stall_i=1 -> WAIT_STALL else IDLE.
//   - TIMEOUT_CYCLES!=0 & counter==TIMEOUT_CYCLES-1 & no ack: bus_select_o<=0,
//     bus_we_o<=0, bus_err_o<=1 (one cycle), rd_buf<=0, go IDLE;
//     stall_req_o=0 and cpu_data_o=0 in this cycle.
//   - else stall_req_o=1, counter++ (saturating, width ceil(log2(T+1))).
//  WAIT_STALL: stall_req_o=0, cpu_data_o=rd_buf, no bus activity.
//   stall_i=0 or flush_i=1 -> IDLE (flush also clears rd_buf).
//  Latency: request in cycle N, select high from N+1; ack in cycle M (M>=N+1)
//   releases stall in M. Min read = 2 cycles.
//  bus_select_o is low at least one cycle between transactions (returns via IDLE).
//  cpu_ce_i ignored outside IDLE; new request only sampled in IDLE.
//  Reset mid-BUSY: drop select next edge, IDLE, no err pulse.
// TESTING
//  1 rst=1 2 cycles -> all outputs 0, state IDLE; ack while IDLE -> no effect.
//  2 read addr 0x0000_0040, ack on 3rd BUSY cycle with 0xDEADBEEF -> stall_req
//    high 3 cycles, cpu_data_o=0xDEADBEEF in ack cycle, select low next cycle.
//  3 write 0x1234_5678 @0x80, ack after 1 cycle -> bus_we_o=1,data held until
//    ack; cpu_data_o=0; back-to-back second write shows 1-cycle select gap.
//  4 read acked while stall_i=1 for 3 cycles -> cpu_data_o holds rd_buf in
//    WAIT_STALL, returns to IDLE when stall_i falls.
//  5 flush_i in 2nd BUSY cycle with simultaneous ack -> ack ignored, select 0
//    next cycle, cpu_data_o=0, no err.
//  6 TIMEOUT_CYCLES=4, no ack -> select high 4 cycles, bus_err_o 1-cycle pulse,
//    stall_req_o 0 in 4th BUSY cycle, state IDLE.

Source files
------------

// File: rtl/wb_master_if.sv
// ----------------------------------------------------------------------------
// wb_master_if
//
// CPU-side bus master for the MIPS data or instruction port. A one-cycle
// memory request from the MEM stage is turned into a bus transaction that is
// held stable until the slave acknowledges. The pipeline is stalled while the
// transaction is in flight, and read data is returned to the MEM stage.
//
// Parameters
//   ADDR_W          bus/CPU address width
//   DATA_W          bus/CPU data width
//   TIMEOUT_CYCLES  BUSY cycles without ack before the transaction is aborted
//                   (0 disables the timeout)
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   cpu_ce_i       request valid (only looked at in IDLE)
//   cpu_we_i       1 = write, 0 = read
//   cpu_addr_i     request address
//   cpu_data_i     write data
//   cpu_data_o     read data to the MEM stage (combinational)
//   stall_i        pipeline held by another source
//   flush_i        pipeline flush, aborts any request
//   stall_req_o    stall request to ctrl (combinational)
//   bus_err_o      one-cycle pulse after a timeout abort
//   bus_addr_o     registered bus address
//   bus_data_o     registered bus write data
//   bus_data_i     bus read data, valid with ack
//   bus_select_o   registered bus strobe/select
//   bus_we_o       registered bus write enable
//   bus_ack_i      slave acknowledge
// ----------------------------------------------------------------------------
module wb_master_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_select_o,
    output logic              bus_we_o,
    input  logic              bus_ack_i
);

    // Counter is wide enough to hold TIMEOUT_CYCLES; keep at least one bit
    // so the design still elaborates when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   rd_buf_r;
    logic [DATA_W-1:0]   rd_buf_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [ADDR_W-1:0]   bus_addr_s;
    logic [DATA_W-1:0]   bus_data_s;
    logic                bus_select_s;
    logic                bus_we_s;
    logic                bus_err_s;
    logic                timeout_hit_s;

    assign timeout_hit_s = TIMEOUT_EN && (cnt_r == CNT_LAST);

    // Next-state, next-register and combinational output logic.
    always_comb begin
        state_s      = state_r;
        rd_buf_s     = rd_buf_r;
        cnt_s        = cnt_r;
        bus_addr_s   = bus_addr_o;
        bus_data_s   = bus_data_o;
        bus_select_s = bus_select_o;
        bus_we_s     = bus_we_o;
        bus_err_s    = 1'b0;
        stall_req_o  = 1'b0;
        cpu_data_o   = {DATA_W{1'b0}};

        case (state_r)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    bus_addr_s   = cpu_addr_i;
                    bus_data_s   = cpu_data_i;
                    bus_we_s     = cpu_we_i;
                    bus_select_s = 1'b1;
                    cnt_s        = {CNT_W{1'b0}};
                    stall_req_o  = 1'b1;
                    state_s      = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end

            BUSY: begin
                // Flush wins over a same-cycle ack: the result is discarded.
                if (flush_i) begin
                    bus_select_s = 1'b0;
                    bus_we_s     = 1'b0;
                    rd_buf_s     = {DATA_W{1'b0}};
                    state_s      = IDLE;
                end else if (bus_ack_i) begin
                    bus_select_s = 1'b0;
                    bus_we_s     = 1'b0;
                    if (bus_we_o) begin
                        rd_buf_s = {DATA_W{1'b0}};
                    end else begin
                        rd_buf_s   = bus_data_i;
                        cpu_data_o = bus_data_i;
                    end
                    // Keep the read data visible while ctrl holds the pipe.
                    if (stall_i) begin
                        state_s = WAIT_STALL;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (timeout_hit_s) begin
                    bus_select_s = 1'b0;
                    bus_we_s     = 1'b0;
                    bus_err_s    = 1'b1;
                    rd_buf_s     = {DATA_W{1'b0}};
                    state_s      = IDLE;
                end else begin
                    stall_req_o = 1'b1;
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end

            WAIT_STALL: begin
                cpu_data_o = rd_buf_r;
                if (flush_i) begin
                    rd_buf_s = {DATA_W{1'b0}};
                    state_s  = IDLE;
                end else if (!stall_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_STALL;
                end
            end

            default: begin
                bus_select_s = 1'b0;
                bus_we_s     = 1'b0;
                state_s      = IDLE;
            end
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rd_buf_r     <= {DATA_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            bus_addr_o   <= {ADDR_W{1'b0}};
            bus_data_o   <= {DATA_W{1'b0}};
            bus_select_o <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            state_r      <= state_s;
            rd_buf_r     <= rd_buf_s;
            cnt_r        <= cnt_s;
            bus_addr_o   <= bus_addr_s;
            bus_data_o   <= bus_data_s;
            bus_select_o <= bus_select_s;
            bus_we_o     <= bus_we_s;
            bus_err_o    <= bus_err_s;
        end
    end

endmodule
